camera_frame_capture: RTL and testbench
=======================================

// Module: camera_frame_capture
// PURPOSE
//  Upstream stage of spi_slave_camera. Samples an OV7670-style parallel camera bus (pclk/vsync/href/d[7:0])
//  in the system clk domain and writes one complete frame into SPRAM. It then raises buffer_ready, which
//  lets the SPI slave drain the frame. It re-arms only after frame_read_complete, so the SPI slave never
//  reads a half-written frame.
// PARAMETERS
//  IMG_W      160  pixels per line
//  IMG_H      120  lines per frame
//  ADDR_W     17   SPRAM byte-address width; frame byte count must be <= 2**ADDR_W
// PORTS
//  clk                  in   1       system clock; must be >= 4x cam_pclk
//  nreset               in   1       asynchronous, active-low reset
//  cam_pclk             in   1       camera pixel clock, asynchronous; treated as data
//  cam_vsync            in   1       high = vertical blanking
//  cam_href             in   1       high = valid bytes on cam_data
//  cam_data             in   8       camera byte bus
//  capture_enable       in   1       level; 0 = finish current state, then stay idle
//  spram_wr_addr        out  ADDR_W  byte write address
//  spram_wr_data        out  8       byte write data
//  spram_wr_en          out  1       one-cycle write strobe
//  buffer_ready         out  1       full valid frame in SPRAM, owned by reader
//  frame_read_complete  in   1       one-cycle pulse from spi_slave_camera
//  capturing            out  1       high while in CAPTURE
//  frame_error          out  1       one-cycle pulse: malformed frame discarded
// BEHAVIOUR
//  - Reset: state=IDLE, every output 0, all counters 0. Reset mid-frame aborts the capture; SPRAM contents are undefined.
//  - Input sync: 2-flop sync on pclk/vsync/href/data, plus a third pclk flop for edge detect.
//    - A byte is taken on a synced pclk rising edge while synced href=1; data comes from the same stage as pclk.
//    - The vsync edges used below are on the synced vsync.
//  - FSM:
//    - IDLE -> WAIT_VS when capture_enable=1 and buffer_ready=0.
//    - WAIT_VS -> CAPTURE on vsync falling edge (frame start). Clears addr, line_cnt and byte_cnt.
//    - CAPTURE: each accepted byte with byte_cnt < LINE_BYTES is written.
//      - The write (spram_wr_en=1 with addr/data) is registered one clk after the edge detect.
//      - addr then increments; bytes beyond LINE_BYTES in a line are dropped.
//      - On href falling edge: if byte_cnt != 0, then line_cnt++ and byte_cnt=0.
//    - CAPTURE on vsync rising edge (frame end):
//      - line_cnt==IMG_H and addr==FRAME_BYTES -> DONE, buffer_ready=1 on the next clk.
//      - Otherwise frame_error pulses and the FSM returns to WAIT_VS; buffer_ready stays 0.
//    - DONE: buffer_ready held 1 and no SPRAM writes. On frame_read_complete: buffer_ready=0 next clk, go to IDLE.
//  - Address never exceeds FRAME_BYTES-1. Writes at addr==FRAME_BYTES are suppressed; the frame then ends with an error.
//  - capture_enable dropping in WAIT_VS returns the FSM to IDLE. In CAPTURE and DONE it takes effect after the frame.
//  - Simultaneous vsync rise and final byte edge: the byte is written first, then the frame-end check runs.
//  - frame_read_complete outside DONE is ignored.
// CONFIGURATION
//  - CAM_CAPTURE_YONLY_EN defined: input is YUV422 (Y,U,Y,V...).
//    - Only even-index bytes of each line (luma) are written.
//    - LINE_BYTES=IMG_W, FRAME_BYTES=IMG_W*IMG_H (19200 at defaults).
//    - Byte parity resets at each href rise.
//  - Not defined: every byte is written (RGB565/YUV raw).
//    - LINE_BYTES=2*IMG_W, FRAME_BYTES=2*IMG_W*IMG_H (38400 at defaults).
//  - In both modes, byte_cnt counts every accepted input byte; the line check compares against input bytes/line = 2*IMG_W.
// STRUCTURE
//  - cam_capture_pkg holds:
//    - state enum cap_state_t {IDLE, WAIT_VS, CAPTURE, DONE};
//    - ADDR_W default;
//    - function frame_bytes(w,h,yonly);
//    - function line_bytes(w,yonly).
//  - Sub-module cam_input_sync: the 2/3-flop synchronizer plus edge detect.
//    - Outputs pclk_rise, href_fall, vsync_rise, vsync_fall, href_s, data_s[7:0].
//  - The top level holds the FSM, counters and write port.
// TESTING
//  - Nominal frame, no macro, IMG_W=4 IMG_H=2:
//    - Stimulus: vsync fall, 2 lines of 8 bytes 0x00..0x0F, then vsync rise.
//    - Response: 16 writes, addr 0..15 with data=addr; buffer_ready=1 two clks after synced vsync rise; frame_error=0.
//  - Same frame with CAM_CAPTURE_YONLY_EN:
//    - Response: 8 writes, addr 0..7, data 0x00,0x02,...,0x0E; buffer_ready=1.
//  - Short frame: only 1 line sent before vsync rise -> frame_error pulses once, buffer_ready=0, FSM back in WAIT_VS.
//  - Long line (10 bytes): bytes 8,9 not written; frame with 2 correct lines otherwise -> buffer_ready=1, no write at addr>=16.
//  - Handshake:
//    - While buffer_ready=1, send another full frame -> no spram_wr_en.
//    - Pulse frame_read_complete -> buffer_ready=0 next clk; the following frame is captured from addr 0.
//  - Reset mid-frame: nreset=0 after 5 bytes -> all outputs 0 immediately; after release, the next complete frame
//    captures normally from addr 0.

Source files
------------

// File: rtl/cam_capture_pkg.sv
// Shared types and frame-geometry helpers for camera_frame_capture.
// Build option CAM_CAPTURE_YONLY_EN: keep only the luma bytes of a YUV422 stream.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  localparam int CAP_ADDR_W_DEFAULT = 17;

`ifdef CAM_CAPTURE_YONLY_EN
  localparam bit YONLY = 1'b1;
`else
  localparam bit YONLY = 1'b0;
`endif

  // Bytes stored per line: luma-only keeps one byte of every input pair.
  function automatic int line_bytes(input int w, input bit yonly);
    return yonly ? w : 2 * w;
  endfunction

  function automatic int frame_bytes(input int w, input int h, input bit yonly);
    return line_bytes(w, yonly) * h;
  endfunction

endpackage

// File: rtl/cam_input_sync.sv
// Brings the asynchronous camera bus into the clk domain and flags pclk/href/vsync edges.
// pclk is sampled as data, so clk must run at least 4x faster than the camera pixel clock.
module cam_input_sync (
  input  logic       clk,
  input  logic       nreset,
  input  logic       cam_pclk,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  output logic       pclk_rise,
  output logic       href_fall,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic       href_s,
  output logic [7:0] data_s
);

  typedef struct packed {
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] data;
  } cam_bus_t;

  cam_bus_t meta_q, sync_q;
  logic     pclk_prev_q, vsync_prev_q, href_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta_q       <= '0;
      sync_q       <= '0;
      pclk_prev_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
    end else begin
      meta_q       <= '{pclk: cam_pclk, vsync: cam_vsync, href: cam_href, data: cam_data};
      sync_q       <= meta_q;
      pclk_prev_q  <= sync_q.pclk;
      vsync_prev_q <= sync_q.vsync;
      href_prev_q  <= sync_q.href;
    end
  end

  // Data travels in the same stage as pclk, so it is stable when the rising edge is seen.
  assign pclk_rise  =  sync_q.pclk  & ~pclk_prev_q;
  assign href_fall  = ~sync_q.href  &  href_prev_q;
  assign vsync_rise =  sync_q.vsync & ~vsync_prev_q;
  assign vsync_fall = ~sync_q.vsync &  vsync_prev_q;
  assign href_s     =  sync_q.href;
  assign data_s     =  sync_q.data;

endmodule

// File: rtl/camera_frame_capture.sv
// Captures one complete camera frame into SPRAM and holds it for the SPI reader until released.
// Build option CAM_CAPTURE_YONLY_EN (see cam_capture_pkg) stores luma bytes only.
module camera_frame_capture
  import cam_capture_pkg::*;
#(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = CAP_ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              capture_enable,
  output logic [ADDR_W-1:0] spram_wr_addr,
  output logic [7:0]        spram_wr_data,
  output logic              spram_wr_en,
  output logic              buffer_ready,
  input  logic              frame_read_complete,
  output logic              capturing,
  output logic              frame_error
);

  localparam int CNT_W         = 16;
  localparam int IN_LINE_BYTES = 2 * IMG_W;
  localparam int FRAME_BYTES   = frame_bytes(IMG_W, IMG_H, YONLY);

  // Address counter is one bit wider so it can sit at FRAME_BYTES == 2**ADDR_W.
  localparam logic [ADDR_W:0]    ADDR_END = (ADDR_W + 1)'(FRAME_BYTES);
  localparam logic [CNT_W-1:0]   LINE_END = CNT_W'(IN_LINE_BYTES);
  localparam logic [CNT_W-1:0]   LINE_NUM = CNT_W'(IMG_H);

  logic       pclk_rise, href_fall, vsync_rise, vsync_fall, href_s;
  logic [7:0] data_s;

  cam_input_sync u_sync (
    .clk        (clk),
    .nreset     (nreset),
    .cam_pclk   (cam_pclk),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .pclk_rise  (pclk_rise),
    .href_fall  (href_fall),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href_s     (href_s),
    .data_s     (data_s)
  );

  cap_state_t        state_q, state_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              buffer_ready_q, buffer_ready_d;
  logic              frame_error_q, frame_error_d;
  logic              keep_byte;

  // Luma bytes sit at even positions; byte_cnt restarts every line so its LSB is the parity.
  assign keep_byte = (byte_cnt_q < LINE_END) && (!YONLY || !byte_cnt_q[0]) && (addr_q < ADDR_END);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    byte_cnt_d     = byte_cnt_q;
    line_cnt_d     = line_cnt_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    buffer_ready_d = (state_q == DONE) && !frame_read_complete;
    frame_error_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (capture_enable && !buffer_ready_q) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (!capture_enable) begin
          state_d = IDLE;
        end else if (vsync_fall) begin
          state_d    = CAPTURE;
          addr_d     = '0;
          byte_cnt_d = '0;
          line_cnt_d = '0;
        end
      end
      CAPTURE: begin
        if (pclk_rise && href_s) begin
          if (keep_byte) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q[ADDR_W-1:0];
            wr_data_d = data_s;
            addr_d    = addr_q + 1'b1;
          end
          if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 1'b1;
        end
        if (href_fall && (byte_cnt_q != '0)) begin
          byte_cnt_d = '0;
          if (line_cnt_q != '1) line_cnt_d = line_cnt_q + 1'b1;
        end
        // Judge the frame on the updated counts so a coincident last byte still counts.
        if (vsync_rise) begin
          if ((line_cnt_d == LINE_NUM) && (addr_d == ADDR_END)) begin
            state_d = DONE;
          end else begin
            state_d       = WAIT_VS;
            frame_error_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (frame_read_complete) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      byte_cnt_q     <= '0;
      line_cnt_q     <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      buffer_ready_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      byte_cnt_q     <= byte_cnt_d;
      line_cnt_q     <= line_cnt_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      buffer_ready_q <= buffer_ready_d;
      frame_error_q  <= frame_error_d;
    end
  end

  assign spram_wr_en   = wr_en_q;
  assign spram_wr_addr = wr_addr_q;
  assign spram_wr_data = wr_data_q;
  assign buffer_ready  = buffer_ready_q;
  assign frame_error   = frame_error_q;
  assign capturing     = (state_q == CAPTURE);

endmodule

// File: tb/tb_camera_frame_capture.sv
// Directed bench for camera_frame_capture at IMG_W=4, IMG_H=2 (both build options).
module tb_camera_frame_capture;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int ADDR_W = 8;
`ifdef CAM_CAPTURE_YONLY_EN
  localparam bit TB_YONLY = 1'b1;
`else
  localparam bit TB_YONLY = 1'b0;
`endif
  localparam int TB_FRAME = TB_YONLY ? IMG_W * IMG_H : 2 * IMG_W * IMG_H;

  logic              clk;
  logic              nreset;
  logic              cam_pclk, cam_vsync, cam_href;
  logic [7:0]        cam_data;
  logic              capture_enable;
  logic [ADDR_W-1:0] spram_wr_addr;
  logic [7:0]        spram_wr_data;
  logic              spram_wr_en;
  logic              buffer_ready;
  logic              frame_read_complete;
  logic              capturing;
  logic              frame_error;

  camera_frame_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk                 (clk),
    .nreset              (nreset),
    .cam_pclk            (cam_pclk),
    .cam_vsync           (cam_vsync),
    .cam_href            (cam_href),
    .cam_data            (cam_data),
    .capture_enable      (capture_enable),
    .spram_wr_addr       (spram_wr_addr),
    .spram_wr_data       (spram_wr_data),
    .spram_wr_en         (spram_wr_en),
    .buffer_ready        (buffer_ready),
    .frame_read_complete (frame_read_complete),
    .capturing           (capturing),
    .frame_error         (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mon_addr[$];
  int mon_data[$];
  int err_seen = 0;
  bit cap_seen = 1'b0;

  typedef struct {
    int n_lines;
    int len0;
    int len1;
    bit exp_ready;
    int exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (spram_wr_en) begin
        mon_addr.push_back(int'(spram_wr_addr));
        mon_data.push_back(int'(spram_wr_data));
      end
      if (frame_error) err_seen++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One camera byte: pclk held low then high for 3 clk periods each.
  task automatic cam_byte(input logic [7:0] b);
    cam_data = b;
    cam_pclk = 1'b0;
    wait_clks(3);
    cam_pclk = 1'b1;
    wait_clks(3);
  endtask

  task automatic send_frame(input int n_lines, input int len0, input int len1);
    int len;
    cap_seen  = 1'b0;
    cam_vsync = 1'b1;
    wait_clks(8);
    cam_vsync = 1'b0;
    wait_clks(6);
    for (int l = 0; l < n_lines; l++) begin
      len = (l == 0) ? len0 : len1;
      cam_href = 1'b1;
      for (int i = 0; i < len; i++) cam_byte(8'(l * 8 + i));
      if (capturing) cap_seen = 1'b1;
      cam_href = 1'b0;
      wait_clks(6);
    end
    cam_vsync = 1'b1;
    wait_clks(12);
  endtask

  // Expected writes follow the camera stream: line byte i has value 8*l+i.
  task automatic run_frame(input string tag, input int n_lines, input int len0, input int len1,
                           input bit exp_wr, input bit exp_ready, input int exp_err, input bit exp_cap);
    int exp_a[$];
    int exp_d[$];
    int addr;
    int len;
    int n;
    addr = 0;
    if (exp_wr) begin
      for (int l = 0; l < n_lines; l++) begin
        len = (l == 0) ? len0 : len1;
        for (int i = 0; i < len; i++) begin
          if (i < 2 * IMG_W && (!TB_YONLY || (i % 2 == 0)) && addr < TB_FRAME) begin
            exp_a.push_back(addr);
            exp_d.push_back(l * 8 + i);
            addr++;
          end
        end
      end
    end
    mon_addr.delete();
    mon_data.delete();
    err_seen = 0;
    send_frame(n_lines, len0, len1);
    check({tag, "_nwrites"}, mon_addr.size(), exp_a.size());
    n = (mon_addr.size() < exp_a.size()) ? mon_addr.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), mon_addr[i], exp_a[i]);
      check($sformatf("%s_data%0d", tag, i), mon_data[i], exp_d[i]);
    end
    check({tag, "_ready"}, int'(buffer_ready), int'(exp_ready));
    check({tag, "_errpulses"}, err_seen, exp_err);
    check({tag, "_capturing"}, int'(cap_seen), int'(exp_cap));
  endtask

  task automatic release_frame();
    @(negedge clk);
    frame_read_complete = 1'b1;
    @(negedge clk);
    frame_read_complete = 1'b0;
    wait_clks(2);
  endtask

  initial begin
    vecs[0] = '{n_lines: 2, len0: 8,  len1: 8, exp_ready: 1'b1, exp_err: 0};  // nominal
    vecs[1] = '{n_lines: 1, len0: 8,  len1: 8, exp_ready: 1'b0, exp_err: 1};  // short frame
    vecs[2] = '{n_lines: 2, len0: 10, len1: 8, exp_ready: 1'b1, exp_err: 0};  // long first line
    vecs[3] = '{n_lines: 3, len0: 8,  len1: 8, exp_ready: 1'b0, exp_err: 1};  // extra line, clipped
    vecs[4] = '{n_lines: 2, len0: 8,  len1: 6, exp_ready: 1'b0, exp_err: 1};  // short last line

    nreset = 1'b1;
    cam_pclk = 1'b0;
    cam_vsync = 1'b0;
    cam_href = 1'b0;
    cam_data = 8'h00;
    capture_enable = 1'b0;
    frame_read_complete = 1'b0;
    #2 nreset = 1'b0;
    wait_clks(3);
    check("rst_wr_en", int'(spram_wr_en), 0);
    check("rst_ready", int'(buffer_ready), 0);
    check("rst_capturing", int'(capturing), 0);
    check("rst_frame_error", int'(frame_error), 0);
    check("rst_addr", int'(spram_wr_addr), 0);
    nreset = 1'b1;
    capture_enable = 1'b1;
    wait_clks(2);

    for (int v = 0; v < 5; v++) begin
      if (buffer_ready) release_frame();
      run_frame($sformatf("vec%0d", v), vecs[v].n_lines, vecs[v].len0, vecs[v].len1,
                1'b1, vecs[v].exp_ready, vecs[v].exp_err, 1'b1);
    end

    // Handshake: a held buffer blocks capture until the reader releases it.
    run_frame("hs_fill", 2, 8, 8, 1'b1, 1'b1, 0, 1'b1);
    run_frame("hs_blocked", 2, 8, 8, 1'b0, 1'b1, 0, 1'b0);
    @(negedge clk);
    frame_read_complete = 1'b1;
    check("hs_ready_before_edge", int'(buffer_ready), 1);
    @(negedge clk);
    frame_read_complete = 1'b0;
    check("hs_ready_after_release", int'(buffer_ready), 0);
    run_frame("hs_rearm", 2, 8, 8, 1'b1, 1'b1, 0, 1'b1);

    // capture_enable low while waiting for vsync parks the FSM in IDLE.
    release_frame();
    capture_enable = 1'b0;
    wait_clks(2);
    run_frame("en_off", 2, 8, 8, 1'b0, 1'b0, 0, 1'b0);
    capture_enable = 1'b1;
    run_frame("en_on", 2, 8, 8, 1'b1, 1'b1, 0, 1'b1);

    // Reset in the middle of a line, then a clean frame.
    release_frame();
    cam_vsync = 1'b1;
    wait_clks(8);
    cam_vsync = 1'b0;
    wait_clks(6);
    cam_href = 1'b1;
    for (int i = 0; i < 5; i++) cam_byte(8'(i + 1));
    check("mid_capturing", int'(capturing), 1);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check("mid_rst_wr_en", int'(spram_wr_en), 0);
    check("mid_rst_addr", int'(spram_wr_addr), 0);
    check("mid_rst_data", int'(spram_wr_data), 0);
    check("mid_rst_ready", int'(buffer_ready), 0);
    check("mid_rst_capturing", int'(capturing), 0);
    check("mid_rst_frame_error", int'(frame_error), 0);
    cam_href = 1'b0;
    cam_vsync = 1'b1;
    wait_clks(4);
    nreset = 1'b1;
    wait_clks(4);
    run_frame("post_rst", 2, 8, 8, 1'b1, 1'b1, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
